// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_rr
//  Description : N-port round-robin arbiter between cache line-fill /
//                write-back requesters and one shared physical memory port.
//                The grant, address and write line are latched at grant time
//                and all outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter_rr #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req_read,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]             req_resp,
    output logic [LINE_WIDTH-1:0]            req_rdata,
    input  logic                             pmem_resp,
    input  logic [LINE_WIDTH-1:0]            pmem_rdata,
    output logic                             pmem_read,
    output logic                             pmem_write,
    output logic [ADDR_WIDTH-1:0]            pmem_address,
    output logic [LINE_WIDTH-1:0]            pmem_wdata
);

    localparam int                 c_IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_PORTS - 1);
    localparam logic [c_IDX_W:0]   c_NUM      = (c_IDX_W + 1)'(NUM_PORTS);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]            r_state;
    logic [c_IDX_W-1:0]    r_gnt;
    logic [c_IDX_W-1:0]    r_rr;
    logic [NUM_PORTS-1:0]  r_req_resp;
    logic [LINE_WIDTH-1:0] r_req_rdata;
    logic                  r_pmem_read;
    logic                  r_pmem_write;
    logic [ADDR_WIDTH-1:0] r_pmem_address;
    logic [LINE_WIDTH-1:0] r_pmem_wdata;

    logic [NUM_PORTS-1:0]  w_req;
    logic [ADDR_WIDTH-1:0] w_addr  [NUM_PORTS];
    logic [LINE_WIDTH-1:0] w_wdata [NUM_PORTS];
    logic                  w_found;
    logic [c_IDX_W-1:0]    w_sel;
    logic [c_IDX_W:0]      w_cand;
    logic [c_IDX_W-1:0]    w_rr_next;
    logic [NUM_PORTS-1:0]  w_onehot;

    assign w_req = req_read | req_write;

    // Split the flat per-port buses into indexable arrays.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        assign w_addr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata[gi] = req_wdata[gi*LINE_WIDTH +: LINE_WIDTH];
    end

    // Search upward from the rotating pointer for the first requesting port.
    // The wrap is an explicit subtract so non-power-of-two port counts work.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_cand = {1'b0, r_rr} + (c_IDX_W + 1)'(k);
            if (w_cand >= c_NUM) begin
                w_cand = w_cand - c_NUM;
            end
            if (!w_found && w_req[w_cand[c_IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_cand[c_IDX_W-1:0];
            end
        end
    end

    // Pointer moves just past the served port; completion pulse is one-hot.
    always_comb begin
        w_rr_next = (r_gnt == c_LAST_IDX) ? '0 : (r_gnt + c_IDX_W'(1));
        w_onehot  = {{(NUM_PORTS-1){1'b0}}, 1'b1} << r_gnt;
    end

    // Grant / memory-transfer / response sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_ST_IDLE;
            r_gnt          <= '0;
            r_rr           <= '0;
            r_req_resp     <= '0;
            r_req_rdata    <= '0;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_found) begin
                        r_gnt          <= w_sel;
                        r_pmem_address <= w_addr[w_sel];
                        r_pmem_wdata   <= w_wdata[w_sel];
                        // A write takes precedence when both bits are set.
                        if (req_write[w_sel]) begin
                            r_pmem_write <= 1'b1;
                            r_pmem_read  <= 1'b0;
                        end else begin
                            r_pmem_write <= 1'b0;
                            r_pmem_read  <= 1'b1;
                        end
                        r_state <= c_ST_BUSY;
                    end
                end
                c_ST_BUSY: begin
                    if (pmem_resp) begin
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                        if (!r_pmem_write) begin
                            r_req_rdata <= pmem_rdata;
                        end
                        r_req_resp <= w_onehot;
                        r_rr       <= w_rr_next;
                        r_state    <= c_ST_RESP;
                    end
                end
                c_ST_RESP: begin
                    // Turnaround cycle: no grant, lets the requester drop.
                    r_req_resp <= '0;
                    r_state    <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign req_resp     = r_req_resp;
    assign req_rdata    = r_req_rdata;
    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_pmem_address;
    assign pmem_wdata   = r_pmem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter_rr
//  Description : Self-checking bench for mem_arbiter_rr with three ports:
//                directed vector table, hand-written reset / spurious
//                response / continuous round-robin sequences, and random
//                transactions checked against a priority-list model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter_rr;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int LW = 256;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_read;
    logic [N-1:0]      req_write;
    logic [N*AW-1:0]   req_addr;
    logic [N*LW-1:0]   req_wdata;
    logic [N-1:0]      req_resp;
    logic [LW-1:0]     req_rdata;
    logic              pmem_resp;
    logic [LW-1:0]     pmem_rdata;
    logic              pmem_read;
    logic              pmem_write;
    logic [AW-1:0]     pmem_address;
    logic [LW-1:0]     pmem_wdata;

    int total;
    int bad;
    int rr_model;
    logic [LW-1:0] last_rdata;

    mem_arbiter_rr #(
        .NUM_PORTS  (N),
        .ADDR_WIDTH (AW),
        .LINE_WIDTH (LW)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_read     (req_read),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_resp     (req_resp),
        .req_rdata    (req_rdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  rd;
        logic [N-1:0]  wr;
        int            port;
        bit            wr_cmd;
        logic [AW-1:0] base;
        logic [LW-1:0] pat;
        logic [LW-1:0] rdat;
        int            dly;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int i = 0; i < LW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Rotating priority list: start just after the last served port.
    function automatic int model_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic check_idle_zero(input string tag);
        check({tag, ".resp"},  LW'(req_resp),     '0);
        check({tag, ".rdata"}, req_rdata,         '0);
        check({tag, ".rd"},    LW'(pmem_read),    '0);
        check({tag, ".wr"},    LW'(pmem_write),   '0);
        check({tag, ".addr"},  LW'(pmem_address), '0);
        check({tag, ".wdata"}, pmem_wdata,        '0);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_read   = '0;
        req_write  = '0;
        pmem_resp  = 1'b0;
        tick();
        rst        = 1'b0;
        rr_model   = 0;
        last_rdata = '0;
    endtask

    // One whole transaction starting in IDLE: grant, hold, complete, turnaround.
    task automatic do_txn(input logic [N-1:0] rd, input logic [N-1:0] wr,
                          input int exp_port, input bit exp_wr,
                          input logic [AW-1:0] base, input logic [LW-1:0] pat,
                          input logic [LW-1:0] rdat, input int dly, input bit hold);
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] exp_wdata;
        logic [LW-1:0] exp_rdata;
        for (int p = 0; p < N; p++) begin
            req_addr[p*AW +: AW]  = base + AW'(p * 64);
            req_wdata[p*LW +: LW] = pat + LW'(p);
        end
        exp_addr  = base + AW'(exp_port * 64);
        exp_wdata = pat + LW'(exp_port);
        req_read  = rd;
        req_write = wr;
        tick();
        check("grant.rd",    LW'(pmem_read),    LW'(!exp_wr));
        check("grant.wr",    LW'(pmem_write),   LW'(exp_wr));
        check("grant.addr",  LW'(pmem_address), LW'(exp_addr));
        check("grant.wdata", pmem_wdata,        exp_wdata);
        if (!hold) begin
            req_read  = N'($urandom);
            req_write = N'($urandom);
            for (int p = 0; p < N; p++) begin
                req_addr[p*AW +: AW]  = $urandom;
                req_wdata[p*LW +: LW] = rand_line();
            end
        end
        for (int d = 0; d < dly; d++) begin
            tick();
            check("busy.addr", LW'(pmem_address), LW'(exp_addr));
            check("busy.cmd",  LW'({pmem_write, pmem_read}), LW'({exp_wr, !exp_wr}));
            check("busy.resp", LW'(req_resp), '0);
        end
        pmem_resp  = 1'b1;
        pmem_rdata = rdat;
        tick();
        pmem_resp  = 1'b0;
        pmem_rdata = rand_line();
        exp_rdata  = exp_wr ? last_rdata : rdat;
        check("done.resp",  LW'(req_resp), LW'(1) << exp_port);
        check("done.rdata", req_rdata, exp_rdata);
        check("done.cmd",   LW'({pmem_write, pmem_read}), '0);
        if (!hold) begin
            req_read  = '0;
            req_write = '0;
        end
        tick();
        check("turn.resp", LW'(req_resp), '0);
        check("turn.cmd",  LW'({pmem_write, pmem_read}), '0);
        last_rdata = exp_rdata;
        rr_model   = (exp_port + 1) % N;
    endtask

    initial begin
        vec_t vecs[7];
        logic [LW-1:0] a5;
        logic [LW-1:0] dead;
        logic [N-1:0]  rd;
        logic [N-1:0]  wr;
        int            ep;

        total      = 0;
        bad        = 0;
        req_addr   = '0;
        req_wdata  = '0;
        pmem_rdata = '0;
        a5         = {(LW/8){8'hA5}};
        dead       = {(LW/32){32'hDEAD_BEEF}};

        // rd, wr, port, write-cmd, base, pattern, read line, busy delay
        vecs[0] = '{3'b010, 3'b000, 1, 1'b0, 32'h0000_1000, rand_line(), a5, 3};
        vecs[1] = '{3'b001, 3'b001, 0, 1'b1, 32'h0000_0100, dead, rand_line(), 2};
        vecs[2] = '{3'b111, 3'b000, 1, 1'b0, 32'h0000_2000, rand_line(), rand_line(), 0};
        vecs[3] = '{3'b011, 3'b100, 2, 1'b1, 32'h0000_3000, rand_line(), rand_line(), 1};
        vecs[4] = '{3'b000, 3'b110, 1, 1'b1, 32'h0000_4000, rand_line(), rand_line(), 4};
        vecs[5] = '{3'b101, 3'b000, 2, 1'b0, 32'h0000_5000, rand_line(), rand_line(), 2};
        vecs[6] = '{3'b100, 3'b010, 1, 1'b1, 32'h0000_6000, rand_line(), rand_line(), 1};

        do_reset();
        rst = 1'b1;
        tick();
        check_idle_zero("reset");
        rst = 1'b0;

        // Spurious memory response with nobody requesting.
        pmem_resp  = 1'b1;
        pmem_rdata = rand_line();
        tick();
        pmem_resp  = 1'b0;
        check_idle_zero("spur1");
        tick();
        check_idle_zero("spur2");

        foreach (vecs[i]) begin
            do_txn(vecs[i].rd, vecs[i].wr, vecs[i].port, vecs[i].wr_cmd,
                   vecs[i].base, vecs[i].pat, vecs[i].rdat, vecs[i].dly, 1'b0);
        end

        // All ports requesting continuously from reset: 0,1,2,0.
        do_reset();
        do_txn(3'b111, 3'b000, 0, 1'b0, 32'h0000_8000, rand_line(), rand_line(), 1, 1'b1);
        do_txn(3'b111, 3'b000, 1, 1'b0, 32'h0000_8000, rand_line(), rand_line(), 2, 1'b1);
        do_txn(3'b111, 3'b000, 2, 1'b0, 32'h0000_8000, rand_line(), rand_line(), 0, 1'b1);
        do_txn(3'b111, 3'b000, 0, 1'b0, 32'h0000_8000, rand_line(), rand_line(), 3, 1'b1);
        req_read = '0;

        // Reset while a read is in flight, then a late memory response.
        req_addr[2*AW +: AW] = 32'h0000_0ABC;
        req_read = 3'b100;
        tick();
        check("midrst.pre_rd", LW'(pmem_read), LW'(1));
        rst      = 1'b1;
        req_read = '0;
        tick();
        rst = 1'b0;
        check_idle_zero("midrst");
        pmem_resp  = 1'b1;
        pmem_rdata = rand_line();
        tick();
        pmem_resp = 1'b0;
        check_idle_zero("late");
        rr_model   = 0;
        last_rdata = '0;
        do_txn(3'b111, 3'b000, 0, 1'b0, 32'h0000_9000, rand_line(), rand_line(), 1, 1'b0);

        // Random traffic against the priority-list model.
        for (int t = 0; t < 40; t++) begin
            rd = N'($urandom);
            wr = N'($urandom) & N'($urandom);
            if ((rd | wr) == '0) rd[$urandom_range(0, N-1)] = 1'b1;
            ep = model_pick(rd | wr, rr_model);
            do_txn(rd, wr, ep, wr[ep], $urandom, rand_line(), rand_line(),
                   $urandom_range(0, 4), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Parametrised N-port round-robin arbiter between per-port cache line-fill/write-back interfaces and one shared physical memory port.
- Generalises the fixed two-port instruction/data arbiter placed below the cache group.
- Adds fair rotating priority, a registered grant with latched address and data, registered outputs, and clean recovery from synchronous reset.

Parameters:
NUM_PORTS, 2, number of requesting caches (>= 2)
ADDR_WIDTH, 32, byte address width
LINE_WIDTH, 256, cache line width in bits

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
req_read  in  NUM_PORTS  per-port line read request, bit i = port i
req_write  in  NUM_PORTS  per-port line write request
req_addr  in  NUM_PORTS*ADDR_WIDTH  per-port address, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_PORTS*LINE_WIDTH  per-port write line, port i at [i*LINE_WIDTH +: LINE_WIDTH]
req_resp  out  NUM_PORTS  one-hot one-cycle completion pulse to granted port
req_rdata  out  LINE_WIDTH  read line, valid while req_resp nonzero (broadcast)
pmem_resp  in  1  memory completion
pmem_rdata  in  LINE_WIDTH  memory read line, sampled when pmem_resp=1
pmem_read  out  1  memory read command
pmem_write  out  1  memory write command
pmem_address  out  ADDR_WIDTH  latched address of granted request
pmem_wdata  out  LINE_WIDTH  latched write line of granted request

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, req_resp=0, req_rdata=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, rr pointer=0 (port 0 highest priority). All outputs are registered.
- Port i is "requesting" when req_read[i] | req_write[i].
- State IDLE:
  - No requests: stay in IDLE.
  - Otherwise grant the first requesting port searching upward from rr pointer, wrapping NUM_PORTS-1 -> 0.
  - At that edge: latch grant index g, pmem_address <= addr[g], pmem_wdata <= wdata[g]; go to BUSY.
  - If req_write[g]=1: pmem_write <= 1, pmem_read <= 0. Write wins if both bits are set.
  - Else: pmem_read <= 1.
- State BUSY:
  - Hold pmem_read/pmem_write/pmem_address/pmem_wdata stable; ignore all req_* changes.
  - On pmem_resp=1: drop pmem_read/pmem_write; req_rdata <= pmem_rdata (reads only; writes leave req_rdata unchanged); req_resp <= one-hot(g); rr pointer <= (g+1) mod NUM_PORTS; go to RESP.
- State RESP:
  - req_resp high for exactly this cycle; clear it on exit.
  - Go to IDLE; no new grant is issued in RESP (one turnaround cycle so the requester can drop its request).
- Latency:
  - Request visible in IDLE at cycle t -> pmem command asserted at t+1.
  - pmem_resp at cycle k -> req_resp at k+1.
  - Minimum 3 cycles from request to the next grant opportunity.
- Fairness: a port just served has lowest priority next arbitration; any continuously requesting port is served within NUM_PORTS grants.
- pmem_resp in IDLE or RESP: ignored, no outputs change.
- Requester dropping its request during BUSY: transaction still completes; req_resp still pulses.
- rst in any state, including BUSY mid-transfer: next edge gives all reset values. A late pmem_resp after reset is ignored in IDLE.
- NUM_PORTS not a power of two: wrap uses explicit compare, not bit truncation.

Test Plan:
- Single read: port 1 req_read, addr 0x0000_1040, NUM_PORTS=2 -> pmem_read=1 next cycle with pmem_address 0x0000_1040; pmem_resp after 4 cycles with rdata 0xA5..A5 -> req_resp=2'b10 for one cycle, req_rdata=0xA5..A5.
- Round-robin, NUM_PORTS=3, all three request continuously from reset -> grant order 0,1,2,0; each req_resp one-hot, no port served twice before the others.
- Write priority/data: port 0 asserts req_read and req_write with wdata 0xDEAD_BEEF replicated -> pmem_write=1, pmem_read=0, pmem_wdata matches; req_rdata unchanged after completion.
- Stability: port 0 changes addr from 0x100 to 0x200 during BUSY -> pmem_address stays 0x100 until pmem_resp.
- Reset mid-operation: rst for one cycle while BUSY with pmem_read=1 -> pmem_read=0 next cycle, req_resp never pulses; subsequent pmem_resp ignored; next request granted from port 0.
- Spurious pmem_resp in IDLE with no requests -> all outputs remain 0.
